mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 128, cache line width in bits.
REQ-002 SHALL have parameter XLEN, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, watchdog limit in cycles (used only under MEM_ARB_TIMEOUT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have port ic_req_valid_i  in  1  icache line-fill request.
REQ-008 SHALL have port ic_req_addr_i  in  XLEN  icache line address.
REQ-009 SHALL have port ic_ready_o  out  1  arbiter can accept an icache request.
REQ-010 SHALL have port ic_res_valid_o  out  1  icache response pulse.
REQ-011 SHALL have port ic_res_data_o  out  BLK_SIZE  icache fill line.
REQ-012 SHALL have ports dc_req_valid_i in 1, dc_req_addr_i in XLEN, dc_req_rw_i in 1 (1=write-back), dc_req_uncached_i in 1, dc_req_data_i in BLK_SIZE: dcache request fields.
REQ-013 SHALL have ports dc_ready_o out 1, dc_res_valid_o out 1, dc_res_data_o out BLK_SIZE: dcache handshake and response.
REQ-014 SHALL have ports mem_req_valid_o out 1, mem_req_ready_i in 1, mem_req_addr_o out XLEN, mem_req_rw_o out 1, mem_req_uncached_o out 1, mem_req_data_o out BLK_SIZE: memory request channel.
REQ-015 SHALL have ports mem_res_valid_i in 1, mem_res_data_i in BLK_SIZE: memory response channel.
REQ-016 SHALL have port arb_err_o  out  1  timeout error pulse (constant 0 without MEM_ARB_TIMEOUT_EN).

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-018 SHALL derive ic_ready_o and dc_ready_o from state only (high iff IDLE), never from request valids, since the caches gate valid with ready.
REQ-019 IDLE with a valid request SHALL grant, latch addr/rw/uncached/data of the winner into request registers, and go to ISSUE next cycle.
REQ-020 SHALL arbitrate round-robin: when both request, the requester not granted last wins; last_grant resets to icache, so dcache wins the first tie.
REQ-021 ISSUE SHALL drive mem_req_valid_o=1 with the latched fields, stay until mem_req_ready_i=1, then go to WAIT; fields SHALL stay stable while valid and not ready.
REQ-022 icache grants SHALL issue with rw=0 and uncached=0.
REQ-023 WAIT SHALL capture mem_res_data_i on mem_res_valid_i and go to RESP; a response arriving in the same cycle as the handshake SHALL be ignored (memory latency at least 1 cycle).
REQ-024 RESP SHALL pulse exactly one of ic_res_valid_o/dc_res_valid_o for one cycle with the captured line, ready low, then return to IDLE.
REQ-025 A dcache write-back and its following refill SHALL be independent transactions; an icache request pending between them MAY be granted.
REQ-026 Response data outputs SHALL hold their last value when res_valid is low.

Reset
REQ-027 Reset SHALL force IDLE, last_grant=icache, request registers and data outputs to 0, all valid outputs 0, arb_err_o 0; ready outputs go to 1 the cycle after reset deasserts.
REQ-028 Reset mid-transaction SHALL abandon it without any response pulse.

Configuration
REQ-029 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle; upon reaching TIMEOUT_CYC, the block SHALL enter RESP with data all-zero and pulse arb_err_o together with the res_valid pulse.
REQ-030 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL be unbounded, and arb_err_o SHALL be tied to 0.

Structure
REQ-031 The FSM state enum typedef SHALL reside in tcore_param; BLK_SIZE and XLEN defaults SHALL come from tcore_param.
REQ-032 SHALL be a single module with no sub-module; the 2-way round-robin logic is inline.

Verification
REQ-033 Lone icache request addr 0x0000_1000, memory response 3 cycles after handshake, data 0xA5..: ic_res_valid_o pulses exactly once with that data; dc_res_valid_o stays 0.
REQ-034 icache and dcache both request in the first cycle after reset: dcache is served first, then icache; on a second simultaneous pair, icache is served first.
REQ-035 dcache write-back (rw=1, addr 0x8000_0040, data 0x1234..): mem_req_rw_o=1 with stable fields while mem_req_ready_i is held low for 4 cycles; a single dc_res_valid_o pulse follows the ack.
REQ-036 Reset asserted during WAIT: no res_valid pulse, both ready outputs read 1 one cycle after reset release, and a late mem_res_valid_i is ignored.
REQ-037 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, no memory response: after 8 WAIT cycles arb_err_o and dc_res_valid_o pulse together with data 0, then the FSM returns to IDLE.
REQ-038 dcache valid held high through RESP: no duplicate grant, because ready stays low in RESP.

Source files
------------

// File: rtl/tcore_param.sv
// Shared core parameters: default bus/line widths and the memory arbiter
// state and grant encodings, imported by mem_arbiter.
package tcore_param;

    localparam int BLK_SIZE_DEF = 128;
    localparam int XLEN_DEF     = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } arb_grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache/dcache) round-robin arbiter in front of a
// single memory request/response channel. One transaction is in flight at
// a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC
// cycles; on expiry a zero line is returned with an arb_err_o pulse.
module mem_arbiter
    import tcore_param::*;
#(
    parameter int BLK_SIZE    = BLK_SIZE_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // icache port
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    output logic                ic_ready_o,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_data_o,
    // dcache port
    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_rw_i,
    input  logic                dc_req_uncached_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    output logic                dc_ready_o,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_data_o,
    // memory request channel
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_rw_o,
    output logic                mem_req_uncached_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    // memory response channel
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_data_i,
    // watchdog error
    output logic                arb_err_o
);

    arb_state_e          state_r;
    arb_grant_e          last_grant_r;
    arb_grant_e          req_src_r;
    logic                ready_r;
    logic                mem_req_valid_r;
    logic [XLEN-1:0]     req_addr_r;
    logic                req_rw_r;
    logic                req_uncached_r;
    logic [BLK_SIZE-1:0] req_data_r;
    logic                ic_res_valid_r;
    logic                dc_res_valid_r;
    logic [BLK_SIZE-1:0] ic_res_data_r;
    logic [BLK_SIZE-1:0] dc_res_data_r;

    logic                grant_s;
    arb_grant_e          winner_s;
    logic                resp_fire_s;
    logic [BLK_SIZE-1:0] resp_line_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             arb_err_r;
    logic             resp_err_s;
`endif

    // Grant decision: only while visibly ready in IDLE; on a tie the port not granted last wins
    always_comb begin
        grant_s  = 1'b0;
        winner_s = GNT_IC;
        if ((state_r == ARB_IDLE) && ready_r) begin
            grant_s = ic_req_valid_i | dc_req_valid_i;
            if (ic_req_valid_i && dc_req_valid_i) begin
                winner_s = (last_grant_r == GNT_IC) ? GNT_DC : GNT_IC;
            end else if (dc_req_valid_i) begin
                winner_s = GNT_DC;
            end else begin
                winner_s = GNT_IC;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = GNT_IC;
        end
    end

    // WAIT exit condition and the line to hand back (zero line on watchdog expiry)
    always_comb begin
        resp_fire_s = mem_res_valid_i;
        resp_line_s = mem_res_data_i;
`ifdef MEM_ARB_TIMEOUT_EN
        resp_err_s  = 1'b0;
        if (!mem_res_valid_i && (wait_cnt_r == CNT_LAST)) begin
            resp_fire_s = 1'b1;
            resp_line_s = {BLK_SIZE{1'b0}};
            resp_err_s  = 1'b1;
        end else begin
            resp_fire_s = mem_res_valid_i;
            resp_line_s = mem_res_data_i;
            resp_err_s  = 1'b0;
        end
`endif
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= ARB_IDLE;
            last_grant_r    <= GNT_IC;
            req_src_r       <= GNT_IC;
            ready_r         <= 1'b0;
            mem_req_valid_r <= 1'b0;
            req_addr_r      <= {XLEN{1'b0}};
            req_rw_r        <= 1'b0;
            req_uncached_r  <= 1'b0;
            req_data_r      <= {BLK_SIZE{1'b0}};
            ic_res_valid_r  <= 1'b0;
            dc_res_valid_r  <= 1'b0;
            ic_res_data_r   <= {BLK_SIZE{1'b0}};
            dc_res_data_r   <= {BLK_SIZE{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_r      <= {CNT_W{1'b0}};
            arb_err_r       <= 1'b0;
`endif
        end else begin
            ic_res_valid_r <= 1'b0;
            dc_res_valid_r <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            arb_err_r      <= 1'b0;
`endif
            case (state_r)
                ARB_IDLE: begin
                    if (grant_s) begin
                        state_r         <= ARB_ISSUE;
                        ready_r         <= 1'b0;
                        mem_req_valid_r <= 1'b1;
                        last_grant_r    <= winner_s;
                        req_src_r       <= winner_s;
                        if (winner_s == GNT_DC) begin
                            req_addr_r     <= dc_req_addr_i;
                            req_rw_r       <= dc_req_rw_i;
                            req_uncached_r <= dc_req_uncached_i;
                            req_data_r     <= dc_req_data_i;
                        end else begin
                            req_addr_r     <= ic_req_addr_i;
                            req_rw_r       <= 1'b0;
                            req_uncached_r <= 1'b0;
                            req_data_r     <= {BLK_SIZE{1'b0}};
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_req_ready_i) begin
                        state_r         <= ARB_WAIT;
                        mem_req_valid_r <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt_r      <= {CNT_W{1'b0}};
`endif
                    end else begin
                        mem_req_valid_r <= 1'b1;
                    end
                end
                ARB_WAIT: begin
                    if (resp_fire_s) begin
                        state_r <= ARB_RESP;
                        if (req_src_r == GNT_DC) begin
                            dc_res_valid_r <= 1'b1;
                            dc_res_data_r  <= resp_line_s;
                        end else begin
                            ic_res_valid_r <= 1'b1;
                            ic_res_data_r  <= resp_line_s;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        arb_err_r <= resp_err_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                    end
                end
                ARB_RESP: begin
                    state_r <= ARB_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r         <= ARB_IDLE;
                    ready_r         <= 1'b0;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ic_ready_o         = ready_r;
    assign dc_ready_o         = ready_r;
    assign ic_res_valid_o     = ic_res_valid_r;
    assign ic_res_data_o      = ic_res_data_r;
    assign dc_res_valid_o     = dc_res_valid_r;
    assign dc_res_data_o      = dc_res_data_r;
    assign mem_req_valid_o    = mem_req_valid_r;
    assign mem_req_addr_o     = req_addr_r;
    assign mem_req_rw_o       = req_rw_r;
    assign mem_req_uncached_o = req_uncached_r;
    assign mem_req_data_o     = req_data_r;
`ifdef MEM_ARB_TIMEOUT_EN
    assign arb_err_o          = arb_err_r;
`else
    assign arb_err_o          = 1'b0;
`endif

endmodule
